// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; clear overrides push and pop, head reads 0 when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  entry_t                   din,
  output logic [$clog2(DEPTH):0]   count,
  output entry_t                   head
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && (count != FULL);
    head    = (count != '0) ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_stage_q.sv
// Fetch stage: PC, credit-limited pipelined imem requests, prefetch queue to decode.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_stage_q
  import fetch_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       QDEPTH   = 4,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] pc, inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  entry_t          head, push_entry;
  logic            push, pop, grant;

  // Outputs are forced idle while rst is low so nothing is requested during reset.
  always_comb begin
    credit_used = {1'b0, count} + (CW+1)'(inflight);
    imem_addr   = (rst && PCSrcE) ? PCTargetE : pc;
    imem_req    = rst && (PCSrcE || (credit_used < (CW+1)'(QDEPTH)));
    grant       = imem_req && imem_gnt;
    push        = imem_rvalid && inflight && !PCSrcE;
    push_entry  = '{pc: inflight_pc, instr: imem_rdata};
    dec_valid   = (count != '0);
    pop         = dec_valid && dec_ready && !PCSrcE;
    PCD         = head.pc;
    InstrD      = head.instr;
    PCPlus4D    = dec_valid ? head.pc + STEP : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= grant;
      if (grant) begin
        inflight_pc <= imem_addr;
        pc          <= imem_addr + STEP;
      end else if (PCSrcE) begin
        pc <= PCTargetE;
      end
    end
  end

  fetch_queue #(
    .DEPTH   (QDEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (PCSrcE),
    .din   (push_entry),
    .count (count),
    .head  (head)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push)                    perf_fetched <= perf_fetched + 32'd1;
      if (dec_valid && !dec_ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage_q.sv
// Directed + randomized bench for fetch_stage_q against a queue-based reference model.
module tb_fetch_stage_q;
  localparam int unsigned QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] InstrD, PCD, PCPlus4D;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  fetch_stage_q #(
    .XLEN     (32),
    .QDEPTH   (QDEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: architectural queue contents, PC, and the one outstanding response.
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_rvalid;
  logic [31:0] m_infl_pc, m_rdata;
  int unsigned m_fetched, m_stall;
  bit          data_rand;
  bit          seq_ok;
  logic [31:0] last_pc;

  logic        o_req, o_valid;
  logic [31:0] o_addr, o_pcd, o_instr, o_plus4;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc      = RESET_PC;
    m_rvalid  = 1'b0;
    m_infl_pc = '0;
    m_rdata   = '0;
    m_fetched = 0;
    m_stall   = 0;
    seq_ok    = 1'b0;
  endtask

  // Entered at posedge+1 (or time 0); leaves the DUT out of reset at posedge+1.
  task automatic do_reset();
    rst = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
    #1;
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_PCD",       PCD,            32'd0);
    check("rst_InstrD",    InstrD,         32'd0);
    check("rst_PCPlus4D",  PCPlus4D,       32'd0);
    check("rst_imem_req",  32'(imem_req),  32'd0);
    check("rst_imem_addr", imem_addr,      RESET_PC);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive, compare against the model, advance the model, cross the edge.
  task automatic step(input logic src, input logic [31:0] tgt, input logic gnt, input logic rdy);
    logic        e_valid, e_req, popped, pushed, granted;
    logic [31:0] e_addr, e_pcd, e_instr, e_plus4;
    PCSrcE      = src;
    PCTargetE   = tgt;
    imem_gnt    = gnt;
    dec_ready   = rdy;
    imem_rvalid = m_rvalid;
    imem_rdata  = m_rvalid ? m_rdata : 32'hDEAD_BEEF;
    #4;
    o_req = imem_req; o_addr = imem_addr; o_valid = dec_valid;
    o_pcd = PCD; o_instr = InstrD; o_plus4 = PCPlus4D;

    e_valid = (mq.size() != 0);
    e_pcd   = e_valid ? mq[0].pc    : 32'd0;
    e_instr = e_valid ? mq[0].instr : 32'd0;
    e_plus4 = e_valid ? mq[0].pc + 32'd4 : 32'd0;
    e_req   = src || ((mq.size() + int'(m_rvalid)) < QDEPTH);
    e_addr  = src ? tgt : m_pc;

    check("dec_valid", 32'(o_valid), 32'(e_valid));
    check("PCD",       o_pcd,        e_pcd);
    check("InstrD",    o_instr,      e_instr);
    check("PCPlus4D",  o_plus4,      e_plus4);
    check("imem_req",  32'(o_req),   32'(e_req));
    check("imem_addr", o_addr,       e_addr);

    popped = e_valid && rdy && !src;
    if (popped) begin
      if (seq_ok) check("pc_seq", o_pcd, last_pc + 32'd4);
      last_pc = o_pcd;
      seq_ok  = 1'b1;
    end
    if (src) seq_ok = 1'b0;

    pushed = m_rvalid && !src;
    if (src) mq.delete();
    else begin
      if (popped) void'(mq.pop_front());
      if (pushed) mq.push_back('{pc: m_infl_pc, instr: m_rdata});
    end
    if (pushed) m_fetched++;
    if (e_valid && !rdy) m_stall++;

    granted  = e_req && gnt;
    m_rvalid = granted;
    if (granted) begin
      m_infl_pc = e_addr;
      m_rdata   = data_rand ? $urandom : (e_addr >> 2);
      m_pc      = e_addr + 32'd4;
    end else if (src) begin
      m_pc = tgt;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int first_valid;
    data_rand = 1'b0;
    do_reset();

    // Streaming from reset: first dec_valid in cycle 3, PCs 0,4,8.. with instr = addr>>2.
    first_valid = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 32'd0, 1'b1, 1'b1);
      if (o_valid && first_valid == 0) first_valid = k;
      if (k >= 3) begin
        check("stream_PCD",    o_pcd,   32'((k - 3) * 4));
        check("stream_InstrD", o_instr, 32'(k - 3));
      end
    end
    check("first_valid_cycle", 32'(first_valid), 32'd3);

    // Mid-stream reset with a full pipe, then a 10-cycle decode stall from restart.
    do_reset();
    for (int k = 1; k <= 10; k++) step(1'b0, 32'd0, 1'b1, 1'b0);
    check("stall_imem_req_low", 32'(o_req),   32'd0);
    check("stall_dec_valid",    32'(o_valid), 32'd1);
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 32'd0, 1'b1, 1'b1);
      check("stall_release_PCD", o_pcd, 32'(j * 4));
    end

    // Build 3 queued + 1 in-flight, then redirect to 0x100.
    step(1'b1, 32'h200, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 32'h100, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check("redir_empty_R1", 32'(o_valid), 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    check("redir_valid_R2", 32'(o_valid), 32'd1);
    check("redir_PCD_R2",   o_pcd,        32'h100);

    // Grant toggling: the model and the pc_seq check catch skips/duplicates.
    for (int k = 0; k < 20; k++) step(1'b0, 32'd0, 1'(k % 2), 1'b1);

    // PC wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    check("wrap_PCD",      o_pcd,   32'hFFFF_FFFC);
    check("wrap_PCPlus4D", o_plus4, 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    check("wrap_next_PCD", o_pcd,   32'd0);

    // Randomized traffic with random data, redirects, and one mid-run reset.
    data_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      step(1'($urandom_range(0, 15) == 0), $urandom & 32'hFFFF_FFFC,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end

`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'(m_fetched));
    check("perf_stall",   perf_stall,   32'(m_stall));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage_q.md
# fetch_stage_q

Parametrised instruction-fetch stage with a prefetch queue between instruction memory and decode. It owns the PC and issues pipelined requests to a granted, fixed-latency instruction memory. It buffers returned {PC, instruction} pairs in a QDEPTH-entry queue and presents them to decode through a valid/ready handshake. Execute-stage redirects flush all buffered and in-flight fetches. It sits between the PC-select logic of execute and the decode stage, and supports decode stalls without losing instructions.

## Interface
- XLEN, 32: PC and instruction width.
- QDEPTH, 4: prefetch queue entries. Must be at least 2 and a power of two.
- RESET_PC, 32'h0000_0000: PC value loaded at reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- PCSrcE  in  1  redirect request from execute.
- PCTargetE  in  XLEN  redirect target address.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid, exactly one cycle after the grant, in order.
- imem_rdata  in  XLEN  instruction word.
- dec_valid  out  1  queue head is valid.
- dec_ready  in  1  decode accepts the head.
- InstrD, PCD, PCPlus4D  out  XLEN  head instruction, its PC, and PC+4.

## Operation
- Fetch address:
  - imem_addr = PCSrcE ? PCTargetE : pc.
  - A request is accepted when imem_req && imem_gnt; pc then becomes imem_addr+4.
  - Otherwise pc holds, except on a redirect, where pc is set to PCTargetE.
- Credit rule:
  - imem_req = PCSrcE || (count + inflight < QDEPTH).
  - count and inflight are registered values; inflight is 1 when a grant occurred in the previous cycle.
  - With this rule the queue never overflows.
- Response: imem_rvalid with no redirect in the same cycle pushes {pc_of_request, imem_rdata}. The request PC is kept in a 1-entry in-flight register.
- Redirect cycle (PCSrcE=1):
  - The queue is cleared.
  - Any imem_rvalid in that cycle is dropped.
  - A pop in that cycle is ignored; dec_valid is still shown, and decode must not rely on it.
  - The request to PCTargetE is issued in the same cycle.
- Pop: dec_valid && dec_ready && !PCSrcE advances the head.
- Push and pop can occur in the same cycle; count is unchanged in that case.
- Outputs:
  - dec_valid = count != 0.
  - InstrD/PCD = head entry; PCPlus4D = PCD+4, taken modulo 2^XLEN.
  - All three read 0 when the queue is empty.
- PC wrap: addition is modulo 2^XLEN, with no trap.

## Timing
- Reset state: pc=RESET_PC, queue empty, inflight=0. All outputs 0 except imem_addr=RESET_PC.
- imem_req rises on the first cycle after reset is released.
- Reset asserted mid-operation discards queue and in-flight state immediately.
- Pipeline latency:
  - Grant in cycle N gives the response in N+1.
  - The entry is visible (dec_valid) in N+2.
- Redirect in cycle R: the target instruction reaches dec_valid in R+2, provided it is granted in R.
- Throughput: one instruction per cycle when imem_gnt=1 and decode is ready.

## Configuration
- FETCH_PERF_EN defined: adds output ports perf_fetched (32-bit count of pushes) and perf_stall (32-bit count of cycles with dec_valid && !dec_ready). Both clear on reset and wrap.
- Not defined: these ports and counters do not exist.

## Structure
- fetch_pkg holds:
  - typedef fetch_entry_t {pc, instr};
  - localparam PC_STEP = 4;
  - the default RESET_PC.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t.
  - Inputs: push, pop, clear.
  - Outputs: count, head.
  - clear has priority over push and pop.

## Test plan
- Reset release, gnt=1, dec_ready=1, imem returns addr>>2 → PCD sequence 0,4,8,…, InstrD 0,1,2,…, first dec_valid in cycle 3.
- dec_ready=0 held 10 cycles, QDEPTH=4 → exactly 4 entries buffered, imem_req low, no loss. Release → 0,4,8,12,16 in order.
- PCSrcE=1, PCTargetE=32'h100 while the queue holds 3 entries and one response is in flight → in-flight response dropped, queue empty, PCD=32'h100 two cycles later.
- imem_gnt toggling 1/0 → no duplicate or skipped PCs.
- pc=32'hFFFF_FFFC → PCPlus4D=0, next PCD=0.
- rst low mid-stream → all outputs 0 at once, restart from RESET_PC. With FETCH_PERF_EN, perf_fetched counts pushes and perf_stall counts stalled-valid cycles.
